expr_result_misr: RTL and testbench



---
 rtl/expr_result_misr.sv | 90 +++++++++
 tb/tb_expr_result_misr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/expr_result_misr.sv
// Result-bus compactor: folds each accepted vector to 32 bits and accumulates it
// into a MISR over a fixed number of vectors, then holds the signature in DONE.
module expr_result_misr #(
    parameter int unsigned IN_W      = 90,
    parameter int unsigned SIG_W     = 32,
    parameter logic [31:0] POLY      = 32'h04C11DB7,
    parameter logic [31:0] SEED      = 32'hFFFFFFFF,
    parameter int unsigned VEC_COUNT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   y,
    output logic [SIG_W-1:0]  sig_out,
    output logic [15:0]       vec_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(VEC_COUNT - 1);

    state_t           state;
    logic [95:0]      y_ext;
    logic [31:0]      fold;
    logic [SIG_W-1:0] sig_next;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_comb begin
        y_ext           = '0;
        y_ext[IN_W-1:0] = y;
        fold            = y_ext[31:0] ^ y_ext[63:32] ^ y_ext[95:64];
        sig_next        = {sig_out[SIG_W-2:0], 1'b0}
                        ^ (sig_out[SIG_W-1] ? POLY : '0)
                        ^ fold;
    end

    // Status flags are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sig_out  <= '0;
            vec_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        sig_out  <= SEED;
                        vec_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        sig_out <= sig_next;
                        vec_cnt <= vec_cnt + 16'd1;
                        if (vec_cnt == LAST_CNT) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_expr_result_misr.sv
// Self-checking bench for expr_result_misr: directed vector table on small
// configurations plus a randomized 256-vector run against a reference model.
module tb_expr_result_misr;

    localparam int unsigned NV = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st  [4];
    logic        vl  [4];
    logic [89:0] ys  [4];
    logic        rdy [4];
    logic [31:0] sig [4];
    logic [15:0] cnt [4];
    logic        bsy [4];
    logic        dn  [4];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    expr_result_misr #(.IN_W(90), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'hFFFFFFFF), .VEC_COUNT(256)) d0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(vl[0]), .in_ready(rdy[0]),
        .y(ys[0]), .sig_out(sig[0]), .vec_cnt(cnt[0]), .busy(bsy[0]), .done(dn[0]));
    expr_result_misr #(.IN_W(90), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'hFFFFFFFF), .VEC_COUNT(1)) d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(vl[1]), .in_ready(rdy[1]),
        .y(ys[1]), .sig_out(sig[1]), .vec_cnt(cnt[1]), .busy(bsy[1]), .done(dn[1]));
    expr_result_misr #(.IN_W(90), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'h00000000), .VEC_COUNT(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(vl[2]), .in_ready(rdy[2]),
        .y(ys[2]), .sig_out(sig[2]), .vec_cnt(cnt[2]), .busy(bsy[2]), .done(dn[2]));
    expr_result_misr #(.IN_W(90), .SIG_W(32), .POLY(32'h04C11DB7), .SEED(32'h00000000), .VEC_COUNT(1)) d3 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .in_valid(vl[3]), .in_ready(rdy[3]),
        .y(ys[3]), .sig_out(sig[3]), .vec_cnt(cnt[3]), .busy(bsy[3]), .done(dn[3]));

    typedef struct {
        int unsigned inst;
        logic        first;
        logic [31:0] seed;
        logic [89:0] y;
        logic [31:0] sig;
        logic [15:0] cnt;
        logic        done;
    } vec_t;

    vec_t        tbl [6];
    logic [89:0] hist [NV];
    logic [31:0] golden;
    logic [31:0] m_sig;
    int unsigned m_cnt;
    int unsigned cyc;
    logic        v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: split the zero-extended vector into three 32-bit words and XOR them.
    function automatic logic [31:0] ref_fold(input logic [89:0] val);
        logic [95:0] w;
        logic [31:0] r;
        w = 96'(val);
        r = '0;
        for (int k = 0; k < 3; k++) r = r ^ 32'(w >> (32 * k));
        return r;
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] f);
        logic [31:0] p;
        p = s[31] ? 32'h04C11DB7 : 32'h0;
        return (s << 1) ^ p ^ f;
    endfunction

    task automatic chk_reset(input int unsigned i, input string tag);
        chk({tag, "_sig"},  sig[i], 32'h0);
        chk({tag, "_cnt"},  32'(cnt[i]), 32'h0);
        chk({tag, "_rdy"},  32'(rdy[i]), 32'h0);
        chk({tag, "_busy"}, 32'(bsy[i]), 32'h0);
        chk({tag, "_done"}, 32'(dn[i]), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            st[i] = 1'b0; vl[i] = 1'b0; ys[i] = '0;
        end
        // y = 1_00000001_00000001 folds to 1 (three set words), y = 1_00000001_00000000 folds to 0.
        tbl[0] = '{1, 1'b1, 32'hFFFFFFFF, 90'h0,                       32'hFB3EE249, 16'd1, 1'b1};
        tbl[1] = '{2, 1'b1, 32'h0,        90'h1,                       32'h00000001, 16'd1, 1'b0};
        tbl[2] = '{2, 1'b0, 32'h0,        90'h1,                       32'h00000003, 16'd2, 1'b1};
        tbl[3] = '{3, 1'b1, 32'h0,        90'h1_00000001_00000001,     32'h00000001, 16'd1, 1'b1};
        tbl[4] = '{3, 1'b1, 32'h0,        90'h1_00000001_00000000,     32'h00000000, 16'd1, 1'b1};
        tbl[5] = '{1, 1'b1, 32'hFFFFFFFF, 90'h3_0000000F_000000F0,     32'hFB3EE2B5, 16'd1, 1'b1};

        repeat (3) tick();
        for (int unsigned i = 0; i < 4; i++) chk_reset(i, "reset");
        rst_n = 1'b1;

        vl[0] = 1'b1; ys[0] = 90'h3FF;
        repeat (3) tick();
        vl[0] = 1'b0;
        chk_reset(0, "idle_valid");

        st[0] = 1'b1; tick(); st[0] = 1'b0;
        repeat (10) tick();
        chk("start_sig",  sig[0], 32'hFFFFFFFF);
        chk("start_busy", 32'(bsy[0]), 32'h1);
        chk("start_rdy",  32'(rdy[0]), 32'h1);
        chk("start_cnt",  32'(cnt[0]), 32'h0);
        chk("start_done", 32'(dn[0]), 32'h0);

        m_sig = 32'hFFFFFFFF; m_cnt = 0; cyc = 0;
        while (m_cnt < NV && cyc < 5000) begin
            v = ($urandom_range(2) != 0);
            vl[0] = v;
            ys[0] = 90'({$urandom(), $urandom(), $urandom()});
            st[0] = ($urandom_range(7) == 0);
            tick();
            cyc++;
            if (v) begin
                m_sig = ref_step(m_sig, ref_fold(ys[0]));
                hist[m_cnt] = ys[0];
                m_cnt++;
            end
            chk("rand_sig",  sig[0], m_sig);
            chk("rand_cnt",  32'(cnt[0]), m_cnt);
            chk("rand_busy", 32'(bsy[0]), 32'(m_cnt < NV));
            chk("rand_rdy",  32'(rdy[0]), 32'(m_cnt < NV));
            chk("rand_done", 32'(dn[0]), 32'(m_cnt == NV));
        end
        st[0] = 1'b0; vl[0] = 1'b0;
        chk("rand_timeout", m_cnt, NV);
        golden = m_sig;

        vl[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ys[0] = 90'($urandom());
            tick();
        end
        vl[0] = 1'b0;
        chk("done_hold_sig",  sig[0], golden);
        chk("done_hold_cnt",  32'(cnt[0]), 32'd256);
        chk("done_hold_done", 32'(dn[0]), 32'h1);

        for (int unsigned t = 0; t < 6; t++) begin
            int unsigned i;
            i = tbl[t].inst;
            if (tbl[t].first) begin
                st[i] = 1'b1; tick(); st[i] = 1'b0;
                chk("tbl_seed", sig[i], tbl[t].seed);
                chk("tbl_rdy0", 32'(rdy[i]), 32'h1);
            end
            vl[i] = 1'b1; ys[i] = tbl[t].y;
            tick();
            vl[i] = 1'b0;
            chk("tbl_sig",  sig[i], tbl[t].sig);
            chk("tbl_cnt",  32'(cnt[i]), 32'(tbl[t].cnt));
            chk("tbl_done", 32'(dn[i]), 32'(tbl[t].done));
            chk("tbl_rdy",  32'(rdy[i]), 32'(!tbl[t].done));
        end

        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            vl[0] = 1'b1; ys[0] = hist[i];
            tick();
        end
        vl[0] = 1'b0;
        chk("pre_rst_cnt", 32'(cnt[0]), 32'd100);
        #2 rst_n = 1'b0;
        #1 chk_reset(0, "mid_rst");
        @(posedge clk); #1 rst_n = 1'b1;

        st[0] = 1'b1; tick(); st[0] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            vl[0] = 1'b1; ys[0] = hist[i];
            tick();
        end
        vl[0] = 1'b0;
        chk("rerun_sig",  sig[0], golden);
        chk("rerun_cnt",  32'(cnt[0]), 32'd256);
        chk("rerun_done", 32'(dn[0]), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
